// File: rtl/pll_lock_supervisor_pkg.sv
// pll_lock_supervisor_pkg: state encodings and retry counter width shared by the lock supervisor
package pll_lock_supervisor_pkg;
  localparam int RETRY_W = 4;
  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;
endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer for asynchronous inputs
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk) begin
    if (rst) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, qualifies lock, releases sys_rst and retries on timeout
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_FILTER_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic               pll_lock,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               locked,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt
);
  localparam int RC_W = RST_PULSE_CYCLES > 1 ? $clog2(RST_PULSE_CYCLES) : 1;
  localparam int FC_W = LOCK_FILTER_CYCLES > 1 ? $clog2(LOCK_FILTER_CYCLES) : 1;
  localparam int TC_W = LOCK_TIMEOUT_CYCLES > 1 ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_PULSE_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(LOCK_FILTER_CYCLES - 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RMAX = RETRY_W'(MAX_RETRIES);
  state_t state, nxt;
  logic lock_s, timeout;
  logic [RC_W-1:0] rst_cnt;
  logic [FC_W-1:0] flt_cnt;
  logic [TC_W-1:0] to_cnt;
  logic [RETRY_W-1:0] retry_inc;
  sync_2ff u_sync (.clk(clk), .rst(rst), .d(pll_lock), .q(lock_s));
  assign timeout   = (state == WAIT_LOCK || state == FILTER) && to_cnt == TC_LAST;
  assign retry_inc = retry_cnt + 1'b1;
  // restart beats timeout, timeout beats lock events
  always_comb begin
    nxt = restart ? RESET_PLL :
          timeout ? (retry_inc == RMAX ? FAULT : RESET_PLL) :
          state == RESET_PLL ? (rst_cnt == RC_LAST ? WAIT_LOCK : RESET_PLL) :
          state == WAIT_LOCK ? (lock_s ? FILTER : WAIT_LOCK) :
          state == FILTER ? (!lock_s ? WAIT_LOCK : flt_cnt == FC_LAST ? RUN : FILTER) :
          state == RUN ? (lock_s ? RUN : RESET_PLL) :
          state == FAULT ? FAULT : RESET_PLL;
  end
  // timeout keeps counting across FILTER<->WAIT_LOCK so a bouncing lock cannot extend it
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RESET_PLL;
      rst_cnt   <= '0;
      flt_cnt   <= '0;
      to_cnt    <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      locked    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= nxt;
      rst_cnt   <= (state == RESET_PLL && nxt == RESET_PLL && !restart) ? rst_cnt + 1'b1 : '0;
      flt_cnt   <= (state == FILTER && nxt == FILTER) ? flt_cnt + 1'b1 : '0;
      to_cnt    <= (state inside {WAIT_LOCK, FILTER} && nxt inside {WAIT_LOCK, FILTER}) ? to_cnt + 1'b1 : '0;
      retry_cnt <= (restart || nxt == RUN) ? '0 : timeout ? retry_inc : retry_cnt;
      pll_rst   <= nxt == RESET_PLL || nxt == FAULT;
      sys_rst   <= nxt != RUN;
      locked    <= nxt == RUN;
      fault     <= nxt == FAULT;
    end
  end
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed checks of reset pulse, filtering, timeout retries, fault and restart
module tb_pll_lock_supervisor;
  logic clk, rst, restart, pll_lock;
  logic pll_rst, sys_rst, locked, fault;
  logic [3:0] retry_cnt;
  int checks = 0;
  int errors = 0;
  logic ever_locked;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES(4), .LOCK_FILTER_CYCLES(8), .LOCK_TIMEOUT_CYCLES(100), .MAX_RETRIES(3)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart), .pll_lock(pll_lock),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .locked(locked), .fault(fault), .retry_cnt(retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic p, input logic s, input logic l,
                         input logic f, input logic [3:0] r);
    chk({tag, ".pll_rst"}, 32'(pll_rst), 32'(p));
    chk({tag, ".sys_rst"}, 32'(sys_rst), 32'(s));
    chk({tag, ".locked"}, 32'(locked), 32'(l));
    chk({tag, ".fault"}, 32'(fault), 32'(f));
    chk({tag, ".retry_cnt"}, 32'(retry_cnt), 32'(r));
  endtask

  initial begin
    rst = 1'b1; restart = 1'b0; pll_lock = 1'b0;
    tick(3);
    chk_all("reset", 1, 1, 0, 0, 0);
    // clean start
    rst = 1'b0;
    tick(3);
    chk("start_pulse_e3", 32'(pll_rst), 1);
    tick(1);
    chk("start_pulse_e4", 32'(pll_rst), 0);
    tick(6);
    pll_lock = 1'b1;
    tick(10);
    chk_all("lock_10", 0, 1, 0, 0, 0);
    tick(1);
    chk_all("lock_11", 0, 0, 1, 0, 0);
    // one-cycle loss of lock in RUN
    tick(5);
    chk("run_hold", 32'(locked), 1);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    chk("loss_edge2", 32'(sys_rst), 0);
    tick(1);
    chk_all("loss_edge3", 1, 1, 0, 0, 0);
    tick(3);
    chk("loss_pulse_3", 32'(pll_rst), 1);
    tick(1);
    chk("loss_pulse_4", 32'(pll_rst), 0);
    tick(8);
    chk("requal_12", 32'(locked), 0);
    tick(1);
    chk_all("requal_13", 0, 0, 1, 0, 0);
    // bouncing lock: 5 high / 1 low never qualifies, timeout after 100 cycles
    pll_lock = 1'b0; restart = 1'b1;
    tick(1);
    restart = 1'b0;
    ever_locked = 1'b0;
    for (int i = 2; i <= 109; i++) begin
      pll_lock = (i % 6) != 0;
      tick(1);
      ever_locked |= locked;
      if (i == 104) chk_all("bounce_z104", 0, 1, 0, 0, 0);
      if (i == 105) chk_all("bounce_timeout", 1, 1, 0, 0, 1);
      if (i == 108) chk("bounce_pulse_3", 32'(pll_rst), 1);
      if (i == 109) chk("bounce_pulse_4", 32'(pll_rst), 0);
    end
    chk("bounce_never_locked", 32'(ever_locked), 0);
    // exhaustion with lock held low
    pll_lock = 1'b0;
    tick(99);
    chk("exh_pre2", 32'(retry_cnt), 1);
    tick(1);
    chk_all("exh_retry2", 1, 1, 0, 0, 2);
    tick(4);
    chk("exh_pulse2_end", 32'(pll_rst), 0);
    tick(99);
    chk_all("exh_pre3", 0, 1, 0, 0, 2);
    tick(1);
    chk_all("exh_fault", 1, 1, 0, 1, 3);
    tick(20);
    chk_all("fault_sticky", 1, 1, 0, 1, 3);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk_all("restart_from_fault", 1, 1, 0, 0, 0);
    tick(3);
    chk("restart_pulse_3", 32'(pll_rst), 1);
    tick(1);
    chk("restart_pulse_4", 32'(pll_rst), 0);
    // restart coinciding with the third timeout
    tick(100);
    chk("sim_retry1", 32'(retry_cnt), 1);
    tick(207);
    chk_all("sim_pre3", 0, 1, 0, 0, 2);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk_all("sim_restart_wins", 1, 1, 0, 0, 0);
    pll_lock = 1'b1;
    tick(7);
    chk_all("sim_in_filter", 0, 1, 0, 0, 0);
    rst = 1'b1;
    tick(1);
    chk_all("rst_mid_filter", 1, 1, 0, 0, 0);
    rst = 1'b0;
    tick(4);
    chk("rst_pulse_4", 32'(pll_rst), 0);
    tick(8);
    chk("rst_requal_12", 32'(locked), 0);
    tick(1);
    chk("rst_requal_13", 32'(locked), 1);
    // restart on the FILTER->RUN edge keeps locked low
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    tick(12);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk_all("restart_at_run_edge", 1, 1, 0, 0, 0);
    tick(12);
    chk("rerun_12", 32'(locked), 0);
    tick(1);
    chk_all("rerun_13", 0, 0, 1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
